jtcps1_bank_server: RTL

- Responder end of the four-bank SDRAM request interface that the CPS1 game top drives: ba0 is read/write, ba1..ba3 are read-only.
- Arbitrates the four banks round-robin and serves one transaction at a time on a simple fixed-latency memory port.
- Inserts periodic refresh slots.
- Used in BRAM/sim-memory builds and as the reference responder for bench checking of the game-side SDRAM mux.

---
 rtl/jtcps1_bank_server.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/jtcps1_bank_server.sv
// Responder for the CPS1 four-bank SDRAM request interface.
// It grants one bank at a time in round-robin order onto a fixed-latency memory port and inserts periodic refresh slots.
module jtcps1_bank_server #(
  parameter int AW         = 22,
  parameter int RD_LAT     = 2,
  parameter int REF_PERIOD = 768,
  parameter int REF_LEN    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ba0_addr,
  input  logic          ba0_rd,
  input  logic          ba0_wr,
  input  logic [15:0]   ba0_din,
  input  logic [1:0]    ba0_din_m,
  input  logic [AW-1:0] ba1_addr,
  input  logic [AW-1:0] ba2_addr,
  input  logic [AW-1:0] ba3_addr,
  input  logic          ba1_rd,
  input  logic          ba2_rd,
  input  logic          ba3_rd,
  output logic          ba0_ack,
  output logic          ba1_ack,
  output logic          ba2_ack,
  output logic          ba3_ack,
  output logic          ba0_rdy,
  output logic          ba1_rdy,
  output logic          ba2_rdy,
  output logic          ba3_rdy,
  output logic [31:0]   data_read,
  input  logic          refresh_en,
  output logic [AW+1:0] mem_addr,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [15:0]   mem_din,
  output logic [1:0]    mem_din_m,
  input  logic [31:0]   mem_dout
);

  typedef enum logic [1:0] {IDLE, RDWAIT, REFRESH} state_t;

  localparam int RCW = $clog2(REF_PERIOD);

  state_t          state;
  logic [RCW-1:0]  ref_cnt;
  logic            ref_pend;
  logic [7:0]      cnt;
  logic [1:0]      ptr;
  logic [1:0]      cur;
  logic            wr_ack;
  logic [3:0]      ack;
  logic [3:0]      rdy;

  logic [3:0]      req;
  logic            found;
  logic [1:0]      sel;
  logic [1:0]      cand;
  logic [AW-1:0]   sel_addr;
  logic            ref_hit;

  assign {ba3_ack, ba2_ack, ba1_ack, ba0_ack} = ack;
  assign {ba3_rdy, ba2_rdy, ba1_rdy, ba0_rdy} = rdy;

  assign req     = {ba3_rd, ba2_rd, ba1_rd, ba0_rd | ba0_wr};
  assign ref_hit = refresh_en && (ref_cnt == RCW'(REF_PERIOD - 1));

  // Search starts one past the last granted bank; the last granted bank is checked last.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    found = 1'b0;
    sel   = ptr;
    cand  = ptr;
    for (int i = 1; i <= 4; i++) begin
      cand = ptr + 2'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    case (sel)
      2'd0:    sel_addr = ba0_addr;
      2'd1:    sel_addr = ba1_addr;
      2'd2:    sel_addr = ba2_addr;
      default: sel_addr = ba3_addr;
    endcase
  end

  // Refresh interval counter: it runs only while refresh is enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
      ref_cnt <= '0;
    end else if (!refresh_en) begin
      ref_cnt <= '0;
    end else if (ref_hit) begin
      ref_cnt <= '0;
    end else begin
      ref_cnt <= ref_cnt + RCW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ref_pend  <= 1'b0;
      cnt       <= '0;
      ptr       <= 2'd0;
      cur       <= 2'd0;
      wr_ack    <= 1'b0;
      ack       <= '0;
      rdy       <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
      mem_din_m <= '0;
      data_read <= '0;
    end else begin
      ack    <= '0;
      rdy    <= '0;
      mem_rd <= 1'b0;
      mem_wr <= 1'b0;
      if (ref_hit) ref_pend <= 1'b1;
      case (state)
        IDLE: begin
          // The cycle after a write ack only issues the write rdy.
          if (wr_ack) begin
            rdy[0] <= 1'b1;
            wr_ack <= 1'b0;
          end else if (ref_pend || ref_hit) begin
            ref_pend <= 1'b0;
            cnt      <= '0;
            state    <= REFRESH;
          end else if (found) begin
            ack[sel]  <= 1'b1;
            ptr       <= sel;
            cur       <= sel;
            mem_addr  <= {sel, sel_addr};
            mem_din   <= ba0_din;
            mem_din_m <= ba0_din_m;
            if (sel == 2'd0 && ba0_wr) begin
              mem_wr <= 1'b1;
              wr_ack <= 1'b1;
            end else begin
              mem_rd <= 1'b1;
              cnt    <= '0;
              state  <= RDWAIT;
            end
          end
        end
        RDWAIT: begin
          if (cnt == 8'(RD_LAT)) begin
            data_read <= mem_dout;
            rdy[cur]  <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        REFRESH: begin
          if (cnt == 8'(REF_LEN - 1)) state <= IDLE;
          else                        cnt   <= cnt + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
